// File: rtl/link_sync_ctrl.sv
// Word-rate comma alignment and link supervision controller for the 8b/10b receive path.
// Drives the deserializer hunt/realign controls and keeps saturating error/loss statistics.
module link_sync_ctrl #(
  parameter int unsigned ACQ_COMMAS      = 3,
  parameter int unsigned ACQ_WINDOW      = 64,
  parameter int unsigned ERR_LIMIT       = 4,
  parameter int unsigned GOOD_TO_RECOVER = 4,
  parameter int unsigned ERR_CNT_W       = 16
) (
  input  logic                 byteclk,
  input  logic                 rst_n,
  input  logic                 word_valid,
  input  logic                 is_comma,
  input  logic                 code_err,
  input  logic                 disp_err,
  input  logic                 clr_cnt,
  output logic                 hunt_en,
  output logic                 realign,
  output logic                 link_up,
  output logic [1:0]           sync_state,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [7:0]           loss_count
);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    CHECK   = 2'd3
  } state_e;

  localparam logic [3:0] ACQ_N   = 4'(ACQ_COMMAS);
  localparam logic [7:0] WIN_N   = 8'(ACQ_WINDOW);
  localparam logic [3:0] ERR_N   = 4'(ERR_LIMIT);
  localparam logic [3:0] GOOD_N  = 4'(GOOD_TO_RECOVER);

  state_e               state_q, state_d;
  logic [3:0]           comma_cnt_q, comma_cnt_d;
  logic [7:0]           win_cnt_q, win_cnt_d;
  logic [3:0]           bad_q, bad_d;
  logic [3:0]           good_q, good_d;
  logic                 realign_q, realign_d;
  logic                 hunt_en_q, link_up_q;
  logic [ERR_CNT_W-1:0] err_count_q;
  logic [7:0]           loss_count_q;
  logic                 err_inc, loss_inc;
  logic                 bad_w, good_w;

  assign bad_w  = word_valid & (code_err | disp_err);
  assign good_w = word_valid & ~(code_err | disp_err);

  always_comb begin
    state_d     = state_q;
    comma_cnt_d = comma_cnt_q;
    win_cnt_d   = win_cnt_q;
    bad_d       = bad_q;
    good_d      = good_q;
    realign_d   = 1'b0;
    err_inc     = 1'b0;
    loss_inc    = 1'b0;
    unique case (state_q)
      HUNT: begin
        if (good_w && is_comma) begin
          comma_cnt_d = 4'd1;
          win_cnt_d   = '0;
          state_d     = (ACQ_N <= 4'd1) ? LOCKED : ACQUIRE;
        end
      end
      ACQUIRE: begin
        if (word_valid) begin
          win_cnt_d = win_cnt_q + 8'd1;
          // Final comma takes priority over a window expiry on the same word.
          if (good_w && is_comma && (comma_cnt_q + 4'd1 == ACQ_N)) begin
            comma_cnt_d = comma_cnt_q + 4'd1;
            state_d     = LOCKED;
          end else if (bad_w || (win_cnt_d == WIN_N)) begin
            state_d   = HUNT;
            realign_d = 1'b1;
          end else if (is_comma) begin
            comma_cnt_d = comma_cnt_q + 4'd1;
          end
        end
      end
      LOCKED: begin
        if (bad_w) begin
          err_inc = 1'b1;
          bad_d   = 4'd1;
          good_d  = '0;
          state_d = (ERR_N <= 4'd1) ? HUNT : CHECK;
        end
      end
      CHECK: begin
        if (bad_w) begin
          err_inc = 1'b1;
          bad_d   = bad_q + 4'd1;
          good_d  = '0;
          if (bad_d == ERR_N) begin
            state_d   = HUNT;
            realign_d = 1'b1;
            loss_inc  = 1'b1;
          end
        end else if (good_w) begin
          good_d = good_q + 4'd1;
          if (good_d == GOOD_N) begin
            good_d = '0;
            bad_d  = bad_q - 4'd1;
            if (bad_d == 4'd0) state_d = LOCKED;
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge byteclk) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      comma_cnt_q  <= '0;
      win_cnt_q    <= '0;
      bad_q        <= '0;
      good_q       <= '0;
      realign_q    <= 1'b0;
      hunt_en_q    <= 1'b1;
      link_up_q    <= 1'b0;
      err_count_q  <= '0;
      loss_count_q <= '0;
    end else begin
      state_q     <= state_d;
      comma_cnt_q <= comma_cnt_d;
      win_cnt_q   <= win_cnt_d;
      bad_q       <= bad_d;
      good_q      <= good_d;
      realign_q   <= realign_d;
      hunt_en_q   <= (state_d == HUNT);
      link_up_q   <= (state_d == LOCKED) || (state_d == CHECK);
      if (clr_cnt)                      err_count_q <= '0;
      else if (err_inc && err_count_q != '1) err_count_q <= err_count_q + 1'b1;
      if (clr_cnt)                       loss_count_q <= '0;
      else if (loss_inc && loss_count_q != '1) loss_count_q <= loss_count_q + 8'd1;
    end
  end

  assign sync_state = state_q;
  assign hunt_en    = hunt_en_q;
  assign realign    = realign_q;
  assign link_up    = link_up_q;
  assign err_count  = err_count_q;
  assign loss_count = loss_count_q;

endmodule

// File: tb/tb_link_sync_ctrl.sv
// Directed bench for link_sync_ctrl: acquisition, window expiry, recovery, loss and counter behaviour.
module tb_link_sync_ctrl;

  logic        byteclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        word_valid = 1'b0, is_comma = 1'b0, code_err = 1'b0, disp_err = 1'b0, clr_cnt = 1'b0;
  logic        hunt_en, realign, link_up;
  logic [1:0]  sync_state;
  logic [15:0] err_count;
  logic [7:0]  loss_count;
  logic        hunt_en2, realign2, link_up2;
  logic [1:0]  sync_state2;
  logic [2:0]  err_count2;
  logic [7:0]  loss_count2;

  int errors = 0;
  int checks = 0;

  always #5 byteclk = ~byteclk;

  link_sync_ctrl #(.ACQ_COMMAS(3), .ACQ_WINDOW(64), .ERR_LIMIT(4),
                   .GOOD_TO_RECOVER(4), .ERR_CNT_W(16)) dut (
    .byteclk(byteclk), .rst_n(rst_n), .word_valid(word_valid), .is_comma(is_comma),
    .code_err(code_err), .disp_err(disp_err), .clr_cnt(clr_cnt), .hunt_en(hunt_en),
    .realign(realign), .link_up(link_up), .sync_state(sync_state),
    .err_count(err_count), .loss_count(loss_count));

  // Narrow error counter and high loss threshold so saturation is reachable while locked.
  link_sync_ctrl #(.ACQ_COMMAS(3), .ACQ_WINDOW(64), .ERR_LIMIT(15),
                   .GOOD_TO_RECOVER(4), .ERR_CNT_W(3)) dut_sat (
    .byteclk(byteclk), .rst_n(rst_n), .word_valid(word_valid), .is_comma(is_comma),
    .code_err(code_err), .disp_err(disp_err), .clr_cnt(clr_cnt), .hunt_en(hunt_en2),
    .realign(realign2), .link_up(link_up2), .sync_state(sync_state2),
    .err_count(err_count2), .loss_count(loss_count2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic v, input logic c, input logic ce, input logic de, input logic cl);
    word_valid = v; is_comma = c; code_err = ce; disp_err = de; clr_cnt = cl;
    @(posedge byteclk);
    #1;
    word_valid = 1'b0; is_comma = 1'b0; code_err = 1'b0; disp_err = 1'b0; clr_cnt = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) send(0, 0, 0, 0, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    chk("rst_state", sync_state, 0);
    chk("rst_hunt", hunt_en, 1);
    chk("rst_realign", realign, 0);
    chk("rst_link", link_up, 0);
    chk("rst_err", err_count, 0);
    chk("rst_loss", loss_count, 0);

    // Acquire with data between commas
    send(1, 1, 0, 0, 0); chk("t1_acq", sync_state, 1); chk("t1_hunt0", hunt_en, 0);
    send(1, 0, 0, 0, 0); send(0, 0, 0, 0, 0);
    send(1, 1, 0, 0, 0); chk("t1_acq2", sync_state, 1); chk("t1_link0", link_up, 0);
    send(1, 0, 0, 0, 0);
    send(1, 1, 0, 0, 0); chk("t1_locked", sync_state, 2); chk("t1_link1", link_up, 1);
    chk("t1_no_realign", realign, 0); chk("t1_hunt_off", hunt_en, 0);

    // One bad word then four good words recovers to LOCKED
    send(1, 0, 1, 0, 0); chk("t4_check", sync_state, 3); chk("t4_link", link_up, 1);
    chk("t4_err1", err_count, 1);
    for (int i = 0; i < 3; i++) begin
      send(1, 0, 0, 0, 0); chk("t4_still_check", sync_state, 3); chk("t4_link_hold", link_up, 1);
    end
    send(1, 0, 0, 0, 0); chk("t4_relocked", sync_state, 2); chk("t4_err_keep", err_count, 1);

    // Four bad words with gaps cause loss
    send(0, 0, 0, 0, 1); chk("t5_clr", err_count, 0);
    for (int i = 0; i < 3; i++) begin
      send(1, 0, 0, 1, 0); send(0, 0, 0, 0, 0);
      chk("t5_check", sync_state, 3); chk("t5_link", link_up, 1); chk("t5_no_realign", realign, 0);
    end
    send(1, 0, 1, 0, 0);
    chk("t5_hunt", sync_state, 0); chk("t5_realign", realign, 1); chk("t5_link0", link_up, 0);
    chk("t5_hunt_en", hunt_en, 1); chk("t5_loss", loss_count, 1); chk("t5_err4", err_count, 4);
    send(0, 0, 0, 0, 0); chk("t5_realign_single", realign, 0);

    // Bad comma in HUNT is ignored; bad word in ACQUIRE realigns
    send(1, 1, 0, 1, 0); chk("t2_bad_comma", sync_state, 0); chk("t2_hunt_realign", realign, 0);
    send(1, 1, 0, 0, 0); chk("t2_acq", sync_state, 1);
    send(1, 0, 1, 0, 0); chk("t2_hunt", sync_state, 0); chk("t2_realign", realign, 1);
    chk("t2_hunt_en", hunt_en, 1); chk("t2_loss_same", loss_count, 1);
    send(0, 0, 0, 0, 0); chk("t2_realign_off", realign, 0);

    // Window expiry after 64 valid non-comma words
    send(1, 1, 0, 0, 0);
    for (int i = 0; i < 63; i++) begin
      send(1, 0, 0, 0, 0);
      if (i == 31) send(0, 0, 0, 0, 0);
    end
    chk("t3_acq_63", sync_state, 1); chk("t3_no_realign_63", realign, 0);
    send(1, 0, 0, 0, 0); chk("t3_expire", sync_state, 0); chk("t3_realign", realign, 1);

    // Third comma on the 64th word wins over expiry
    send(1, 1, 0, 0, 0);
    send(1, 1, 0, 0, 0);
    for (int i = 0; i < 62; i++) send(1, 0, 0, 0, 0);
    chk("t3b_acq_63", sync_state, 1);
    send(1, 1, 0, 0, 0); chk("t3b_locked", sync_state, 2); chk("t3b_no_realign", realign, 0);
    chk("t3b_link", link_up, 1);

    // clr_cnt beats a simultaneous increment, then reset from CHECK
    send(1, 0, 1, 0, 0); chk("t6_check", sync_state, 3); chk("t6_err", err_count, 5);
    send(1, 0, 1, 0, 1); chk("t6_clr_wins", err_count, 0); chk("t6_loss_clr", loss_count, 0);
    chk("t6_still_check", sync_state, 3);
    send(1, 0, 1, 0, 0); chk("t6_err1", err_count, 1);
    rst_n = 1'b0;
    send(1, 0, 1, 0, 0);
    chk("t6_rst_state", sync_state, 0); chk("t6_rst_realign", realign, 0);
    chk("t6_rst_link", link_up, 0); chk("t6_rst_hunt", hunt_en, 1); chk("t6_rst_err", err_count, 0);
    rst_n = 1'b1;
    send(0, 0, 0, 0, 0); chk("t6_post_realign", realign, 0);

    // Error counter saturation on the narrow instance
    repeat (3) send(1, 1, 0, 0, 0);
    chk("sat_locked", sync_state2, 2);
    for (int i = 0; i < 7; i++) send(1, 0, 1, 0, 0);
    chk("sat_at7", err_count2, 7);
    send(1, 0, 1, 0, 0); chk("sat_hold", err_count2, 7); chk("sat_link", link_up2, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/link_sync_ctrl.md
Name: link_sync_ctrl

Overview:
- Word-rate controller that sequences comma alignment and link supervision for the 8b/10b deserializer/decoder path.
- Decides when the deserializer hunts for commas, when the link is declared up, and when it is declared lost and must realign.
- Sits between the bit-level deserializer (which hunts and slips) and the downstream frame logic (which consumes link_up).
- Also keeps saturating error and loss-of-link statistics.

Parameters:
ACQ_COMMAS, 3, consecutive-or-not good commas required in ACQUIRE before LOCKED (1..15)
ACQ_WINDOW, 64, max valid words spent in ACQUIRE before returning to HUNT (2..255)
ERR_LIMIT, 4, bad-word score in CHECK that forces loss of link (2..15)
GOOD_TO_RECOVER, 4, consecutive good words that decrement the bad score (1..15)
ERR_CNT_W, 16, width of err_count

Ports:
byteclk  in  1  word clock; all logic on rising edge
rst_n  in  1  reset, synchronous, active-low
word_valid  in  1  decoder presented a word this cycle
is_comma  in  1  word is K28.5 (either disparity); qualified by word_valid
code_err  in  1  invalid 10b code; qualified by word_valid
disp_err  in  1  running-disparity violation; qualified by word_valid
clr_cnt  in  1  clears err_count and loss_count
hunt_en  out  1  deserializer free-runs its comma search
realign  out  1  one-cycle pulse: deserializer discards alignment and resets its decoder disparity
link_up  out  1  link is usable
sync_state  out  2  0=HUNT, 1=ACQUIRE, 2=LOCKED, 3=CHECK
err_count  out  ERR_CNT_W  saturating count of bad words while link_up
loss_count  out  8  saturating count of LOCKED/CHECK to HUNT transitions

Behaviour:
- Interface: one clock, byteclk; reset rst_n is synchronous and active-low.
- A bad word is word_valid & (code_err | disp_err). A good word is word_valid & no error.
- Cycles with word_valid=0 change no state, counter or score.
- Reset values: sync_state=HUNT, hunt_en=1, realign=0, link_up=0, err_count=0, loss_count=0. All internal counters are 0.
- Asserting rst_n low mid-operation returns to these values on the next edge, with no realign pulse.
- Outputs are registered. Decisions are taken on the edge that samples the word, so outputs change 1 cycle after that word.
- HUNT:
  - hunt_en=1, link_up=0.
  - A good comma moves to ACQUIRE with comma_cnt=1 and win_cnt=0.
  - Non-comma words and bad words are ignored.
- ACQUIRE:
  - hunt_en=0, link_up=0.
  - Each valid word increments win_cnt.
  - A good comma increments comma_cnt; reaching ACQ_COMMAS moves to LOCKED.
  - A bad word moves to HUNT with a realign pulse.
  - If win_cnt reaches ACQ_WINDOW without lock, move to HUNT with a realign pulse.
  - If the final comma and the window expiry occur on the same word, the comma wins and the state goes to LOCKED.
- LOCKED:
  - link_up=1, hunt_en=0.
  - A bad word moves to CHECK with bad=1, good=0.
- CHECK:
  - link_up stays 1.
  - A bad word sets bad+=1 and good=0. If bad reaches ERR_LIMIT, move to HUNT: realign pulse, link_up=0 on the next cycle, loss_count+1.
  - A good word sets good+=1. When good reaches GOOD_TO_RECOVER, bad-=1 and good=0. If bad becomes 0, move to LOCKED.
- err_count:
  - Increments on every bad word while in LOCKED or CHECK, including the word that causes loss.
  - Saturates at all-ones; loss_count saturates at 255.
  - If clr_cnt and an increment occur in the same cycle, clr_cnt wins (result 0).
- realign is high for exactly one cycle per entry into HUNT from ACQUIRE or CHECK. It is never asserted while already in HUNT.

Test Plan:
1. Reset, then 3 good commas with data words between them: sync_state goes HUNT→ACQUIRE→LOCKED. link_up rises 1 cycle after the 3rd comma; hunt_en=0; realign never pulses.
2. In ACQUIRE after 1 comma, drive code_err on a valid word: next cycle sync_state=HUNT, realign=1 for 1 cycle, hunt_en=1.
3. In ACQUIRE, send 64 valid non-comma words: HUNT plus realign after the 64th. Repeat with the 3rd comma landing on the 64th word: LOCKED.
4. From LOCKED, send 1 bad word then 4 good words: CHECK, then LOCKED after the 4th good word. err_count=1, link_up never drops.
5. From LOCKED, send 4 bad words separated by word_valid=0 gaps: HUNT after the 4th bad word. loss_count=1, err_count=4, realign single pulse, link_up=0.
6. Assert clr_cnt on the same cycle as a bad word in CHECK: err_count=0. Force err_count to 0xFFFF and send a bad word: stays 0xFFFF. Drop rst_n in CHECK: all outputs at reset values next edge, no realign.
